// File: rtl/gray_decoder_monitor.sv
// Gray sample decoder with one-bit step, direction and wrap monitoring.
// Optional saturating step-error counter: define GRAY_ERR_CNT_EN.
module gray_decoder_monitor #(
  parameter int N     = 4,
  parameter int ERR_W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [N-1:0] gray_in,
  input  logic         gray_vld,
  output logic [N-1:0] bin_out,
  output logic         bin_vld,
  output logic         step_err,
  output logic         dir_up,
  output logic         wrap
`ifdef GRAY_ERR_CNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  typedef enum logic {
    FIRST,
    TRACK
  } state_t;

  state_t       state;
  logic [N-1:0] prev_gray;
  logic [N-1:0] new_bin;
  logic [N-1:0] prev_bin;
  logic [N-1:0] diff;
  logic         zero_step;
  logic         one_step;
  logic         multi_step;
  logic         up_step;
  logic         at_top;
  logic         at_bot;

  function automatic logic [N-1:0] g2b(
    input logic [N-1:0] g
  );
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign new_bin  = g2b(gray_in);
  assign prev_bin = g2b(prev_gray);
  assign diff     = gray_in ^ prev_gray;

  // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero.
  assign zero_step  = (diff == '0);
  assign one_step   = !zero_step &&
                      ((diff & (diff - N'(1))) == '0);
  assign multi_step = !zero_step && !one_step;

  assign up_step = (new_bin == prev_bin + N'(1));
  assign at_top  = &prev_bin;
  assign at_bot  = ~|prev_bin;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state     <= FIRST;
      prev_gray <= '0;
      bin_out   <= '0;
      bin_vld   <= 1'b0;
      step_err  <= 1'b0;
      dir_up    <= 1'b1;
      wrap      <= 1'b0;
    end else begin
      bin_vld <= gray_vld;
      if (gray_vld) begin
        prev_gray <= gray_in;
        bin_out   <= new_bin;
        step_err  <= 1'b0;
        wrap      <= 1'b0;
        unique case (state)
          FIRST: begin
            state <= TRACK;
          end
          TRACK: begin
            if (one_step) begin
              dir_up <= up_step;
              wrap   <= up_step ? at_top : at_bot;
            end else if (multi_step) begin
              step_err <= 1'b1;
            end
          end
          default: begin
            state <= FIRST;
          end
        endcase
      end
    end
  end

`ifdef GRAY_ERR_CNT_EN
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      err_cnt <= '0;
    end else if (gray_vld && state == TRACK &&
                 multi_step && err_cnt != '1) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end
`endif

endmodule

// File: doc/gray_decoder_monitor.md
Name: gray_decoder_monitor

Overview:
- Receive end of the team's gray counters: accepts a gray-coded count sample stream and decodes it to binary.
- Registers the decoded value and checks that consecutive samples differ by at most one bit (legal gray step).
- Reports step direction and wrap events per sample.
- Sits downstream of gray counter / gray pointer sources; feeds binary consumers (occupancy math, debug monitors).

Parameters:
- N, 4, gray/binary width in bits (N >= 2)
- ERR_W, 8, width of the saturating step-error counter (used only when the optional feature is compiled in)

Ports:
- clk  input  1  clock, all state updates on rising edge
- srst  input  1  asynchronous, active-high reset
- gray_in  input  N  gray-coded sample
- gray_vld  input  1  gray_in is valid this cycle
- bin_out  output  N  decoded binary of the last accepted sample
- bin_vld  output  1  one-cycle pulse: bin_out and the flags below updated
- step_err  output  1  qualified by bin_vld: sample differed from previous in more than one bit
- dir_up  output  1  qualified by bin_vld: last legal one-bit step was +1 mod 2^N
- wrap  output  1  qualified by bin_vld: legal step crossed 2^N-1 <-> 0 in either direction
- err_cnt  output  ERR_W  saturating count of step errors (optional feature only)

Behaviour:
- Reset (srst high, asynchronous assert):
  - bin_out=0, bin_vld=0, step_err=0, dir_up=1, wrap=0, err_cnt=0.
  - Internal prev_gray=0; state=FIRST.
- Decode: bin[N-1]=gray[N-1]; bin[i]=bin[i+1]^gray[i]. Combinational on gray_in, registered to bin_out.
- Latency: gray_vld in cycle t -> bin_vld=1 with bin_out and flags valid in cycle t+1. bin_vld=0 on any cycle after a cycle with gray_vld=0.
- No back-pressure; every gray_vld cycle is accepted.
- State FIRST:
  - On gray_vld: load prev_gray=gray_in, output bin, step_err=0, wrap=0, dir_up unchanged.
  - Go to TRACK.
- State TRACK, on gray_vld, d = popcount(gray_in ^ prev_gray):
  - d=0: bin_out unchanged, step_err=0, wrap=0, dir_up unchanged.
  - d=1, new_bin == prev_bin+1 mod 2^N: dir_up=1; wrap=1 iff prev_bin=2^N-1.
  - d=1, otherwise (the step is necessarily -1): dir_up=0; wrap=1 iff prev_bin=0.
  - d>1: step_err=1, wrap=0, dir_up unchanged, bin_out = decoded new value.
  - prev_gray always updated to gray_in.
  - Remains in TRACK.
- No gray_vld: all registers hold except bin_vld, which drops to 0.
- prev_bin is the decode of prev_gray; arithmetic is modulo 2^N, no carry out.
- srst asserted mid-stream: immediate return to reset values and FIRST. The next sample is never flagged.
- Flags are meaningful only when bin_vld=1 and are held otherwise.

Optional Feature:
- Macro: GRAY_ERR_CNT_EN
- Defined:
  - err_cnt port present.
  - Increments by 1 in the same cycle step_err is raised with bin_vld.
  - Saturates at 2^ERR_W-1.
  - Cleared only by srst.
- Undefined: err_cnt port and counter logic absent; all other behaviour identical.

Test Plan:
- Sequential count (N=4): srst pulse, then gray_vld=1 with gray 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 -> bin_out 0..15 one cycle later each, dir_up=1, step_err=0, wrap=0.
- Wrap both ways: gray 8 then 0 -> bin 15 then 0 with wrap=1, dir_up=1. Then gray 8 -> bin 15, wrap=1, dir_up=0.
- Down step: gray 3 then 1 -> bin 2 then 1, dir_up=0, step_err=0, wrap=0.
- Illegal step: gray 0 then 3 -> bin 2, step_err=1, wrap=0. With GRAY_ERR_CNT_EN, err_cnt 0->1. Force 300 errors with ERR_W=8 -> err_cnt holds 255.
- Gaps and repeats:
  - gray 6, one idle cycle, gray 6 -> bin 4 twice, bin_vld=0 in the gap cycle, no step_err, dir_up unchanged.
- Async reset mid-stream:
  - After gray 7, assert srst between clock edges -> outputs clear without a clock edge.
  - Deassert, then gray 5 -> bin 6, step_err=0 (FIRST state).
